// File: rtl/stage_wb_pkg.sv
// Shared pipeline package: datapath widths, load-size codes, link register and the MEM/WB record.
package pipe_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int LINK_REG = 31;

  // Code 2'b11 is deliberately left undeclared; the load aligner treats it as a word.
  typedef enum logic [1:0] {
    MEM_SIZE_WORD = 2'b00,
    MEM_SIZE_HALF = 2'b01,
    MEM_SIZE_BYTE = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic              valid;
    logic              regWrite;
    logic              memToReg;
    logic              jal;
    mem_size_e         memSize;
    logic              memSigned;
    logic [REG_AW-1:0] writeRegister;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] readData;
    logic [DATA_W-1:0] pcAddResult;
  } mem_wb_t;

endpackage

// File: rtl/stage_wb_if.sv
// MEM-to-WB bundle: MEM-stage fields into the write-back stage and the register-file write port out.
interface stage_wb_if #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW
);
  logic              Valid_in_WB;
  logic              Stall_in_WB;
  logic              Flush_in_WB;
  logic              RegWrite_in_WB;
  logic              MemtoReg_in_WB;
  logic              JAL_in_WB;
  logic [1:0]        MemSize_in_WB;
  logic              MemSigned_in_WB;
  logic [REG_AW-1:0] WriteRegister_in_WB;
  logic [DATA_W-1:0] ALUResult_in_WB;
  logic [DATA_W-1:0] ReadData_in_WB;
  logic [DATA_W-1:0] PCAddResult_in_WB;
  logic              RegWrite_out_WB;
  logic [REG_AW-1:0] WriteRegister_out_WB;
  logic [DATA_W-1:0] WriteData_out_WB;
  logic [31:0]       Retired_out_WB;

  modport master (
    output Valid_in_WB, Stall_in_WB, Flush_in_WB, RegWrite_in_WB, MemtoReg_in_WB, JAL_in_WB,
           MemSize_in_WB, MemSigned_in_WB, WriteRegister_in_WB, ALUResult_in_WB,
           ReadData_in_WB, PCAddResult_in_WB,
    input  RegWrite_out_WB, WriteRegister_out_WB, WriteData_out_WB, Retired_out_WB
  );

  modport slave (
    input  Valid_in_WB, Stall_in_WB, Flush_in_WB, RegWrite_in_WB, MemtoReg_in_WB, JAL_in_WB,
           MemSize_in_WB, MemSigned_in_WB, WriteRegister_in_WB, ALUResult_in_WB,
           ReadData_in_WB, PCAddResult_in_WB,
    output RegWrite_out_WB, WriteRegister_out_WB, WriteData_out_WB, Retired_out_WB
  );
endinterface

// File: rtl/stage_wb_load_align.sv
// Combinational sub-word load formatter: little-endian lane select by address, then zero/sign extend.
module wb_load_align
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] readData,
  input  logic [1:0]        addr,
  input  mem_size_e         size,
  input  logic              isSigned,
  output logic [DATA_W-1:0] loadData
);

  logic [7:0]  byteLane [4];
  logic [15:0] halfLane [2];
  logic [7:0]  selByte;
  logic [15:0] selHalf;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_byte
    assign byteLane[gi] = readData[8*gi +: 8];
  end
  for (gi = 0; gi < 2; gi++) begin : g_half
    assign halfLane[gi] = readData[16*gi +: 16];
  end

  // Halfword lane uses addr[1] only; a misaligned addr[0] is silently ignored.
  always_comb begin
    selByte  = byteLane[addr];
    selHalf  = halfLane[addr[1]];
    loadData = readData;
    case (size)
      MEM_SIZE_BYTE: loadData = {{(DATA_W-8){isSigned & selByte[7]}}, selByte};
      MEM_SIZE_HALF: loadData = {{(DATA_W-16){isSigned & selHalf[15]}}, selHalf};
      default:       loadData = readData;
    endcase
  end

endmodule

// File: rtl/stage_wb.sv
// MIPS write-back stage: MEM/WB register, write-data select and register-file write port.
// Optional retired-instruction counter built only when WB_RETIRE_CNT_EN is defined.
module stage_wb
  import pipe_pkg::*;
#(
  parameter int DATA_W   = pipe_pkg::DATA_W,
  parameter int REG_AW   = pipe_pkg::REG_AW,
  parameter int LINK_REG = pipe_pkg::LINK_REG
) (
  input logic       Clk_in,
  input logic       Reset_in,
  stage_wb_if.slave wb
);

  mem_wb_t           memWb_reg;
  mem_wb_t           memWb_next;
  logic [REG_AW-1:0] dest;
  logic [DATA_W-1:0] loadData;

  // A flushed instruction is still captured, only its valid bit is dropped.
  always_comb begin
    memWb_next = memWb_reg;
    if (!wb.Stall_in_WB) begin
      memWb_next.valid         = wb.Valid_in_WB & ~wb.Flush_in_WB;
      memWb_next.regWrite      = wb.RegWrite_in_WB;
      memWb_next.memToReg      = wb.MemtoReg_in_WB;
      memWb_next.jal           = wb.JAL_in_WB;
      memWb_next.memSize       = mem_size_e'(wb.MemSize_in_WB);
      memWb_next.memSigned     = wb.MemSigned_in_WB;
      memWb_next.writeRegister = wb.WriteRegister_in_WB;
      memWb_next.aluResult     = wb.ALUResult_in_WB;
      memWb_next.readData      = wb.ReadData_in_WB;
      memWb_next.pcAddResult   = wb.PCAddResult_in_WB;
    end
  end

  always_ff @(posedge Clk_in) begin
    if (Reset_in) begin
      memWb_reg <= '0;
    end else begin
      memWb_reg <= memWb_next;
    end
  end

  wb_load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .readData (memWb_reg.readData),
    .addr     (memWb_reg.aluResult[1:0]),
    .size     (memWb_reg.memSize),
    .isSigned (memWb_reg.memSigned),
    .loadData (loadData)
  );

  assign dest = memWb_reg.jal ? REG_AW'(LINK_REG) : memWb_reg.writeRegister;

  // $0 is hardwired, so a write to it is never presented to the register file.
  assign wb.RegWrite_out_WB      = memWb_reg.valid & memWb_reg.regWrite & (dest != '0);
  assign wb.WriteRegister_out_WB = dest;
  assign wb.WriteData_out_WB     = memWb_reg.jal      ? memWb_reg.pcAddResult :
                                   memWb_reg.memToReg ? loadData              :
                                                        memWb_reg.aluResult;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retiredCnt_reg;

  // Counts an instruction once, on the cycle it leaves the register unstalled.
  always_ff @(posedge Clk_in) begin
    if (Reset_in) begin
      retiredCnt_reg <= '0;
    end else if (memWb_reg.valid && !wb.Stall_in_WB) begin
      retiredCnt_reg <= retiredCnt_reg + 32'd1;
    end
  end

  assign wb.Retired_out_WB = retiredCnt_reg;
`else
  assign wb.Retired_out_WB = '0;
`endif

endmodule

// File: tb/tb_stage_wb.sv
// Self-checking bench for stage_wb: scoreboard of expected write-port values, one task per scenario.
module tb_stage_wb;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
  } exp_t;

  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sbQ[$];
  exp_t e;

  stage_wb_if bus ();

  stage_wb dut (
    .Clk_in   (Clk),
    .Reset_in (Reset),
    .wb       (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic drive(input logic v, input logic f, input logic rw, input logic m2r,
                       input logic jal, input logic [1:0] sz, input logic sg, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc);
    bus.Valid_in_WB         = v;
    bus.Flush_in_WB         = f;
    bus.RegWrite_in_WB      = rw;
    bus.MemtoReg_in_WB      = m2r;
    bus.JAL_in_WB           = jal;
    bus.MemSize_in_WB       = sz;
    bus.MemSigned_in_WB     = sg;
    bus.WriteRegister_in_WB = wr;
    bus.ALUResult_in_WB     = alu;
    bus.ReadData_in_WB      = rd;
    bus.PCAddResult_in_WB   = pc;
  endtask

  function automatic exp_t model(input logic v, input logic f, input logic rw, input logic m2r,
                                 input logic jal, input logic [1:0] sz, input logic sg,
                                 input logic [4:0] wr, input logic [31:0] alu,
                                 input logic [31:0] rd, input logic [31:0] pc);
    exp_t        r;
    logic [4:0]  d;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld;
    d = jal ? 5'd31 : wr;
    b = 8'(rd >> {alu[1:0], 3'b000});
    h = alu[1] ? rd[31:16] : rd[15:0];
    if (sz == 2'b10)      ld = sg ? {{24{b[7]}}, b} : {24'h0, b};
    else if (sz == 2'b01) ld = sg ? {{16{h[15]}}, h} : {16'h0, h};
    else                  ld = rd;
    r.rw = v & ~f & rw & (d != 5'd0);
    r.wr = d;
    r.wd = jal ? pc : (m2r ? ld : alu);
    return r;
  endfunction

  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.Stall_in_WB = 1'b0;
    drive(1, 0, 1, 0, 0, 2'b00, 0, 5'd7, 32'h55, 32'h66, 32'h77);
    repeat (2) @(negedge Clk);
    checks++; if (bus.RegWrite_out_WB !== 1'b0) begin errors++; $display("FAIL reset_rw got %b want 0", bus.RegWrite_out_WB); end
    checks++; if (bus.WriteRegister_out_WB !== 5'd0) begin errors++; $display("FAIL reset_wr got %0d want 0", bus.WriteRegister_out_WB); end
    checks++; if (bus.WriteData_out_WB !== 32'h0) begin errors++; $display("FAIL reset_wd got %h want 0", bus.WriteData_out_WB); end
    checks++; if (bus.Retired_out_WB !== 32'h0) begin errors++; $display("FAIL reset_ret got %h want 0", bus.Retired_out_WB); end
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge Clk);
  endtask

  task automatic test_alu();
    drive(1, 0, 1, 0, 0, 2'b00, 0, 5'd8, 32'h1234, 32'hDEADBEEF, 32'h100);
    sbQ.push_back('{1'b1, 5'd8, 32'h00001234});
    @(negedge Clk);
    e = sbQ.pop_front();
    checks++;
    if (bus.RegWrite_out_WB !== e.rw || bus.WriteRegister_out_WB !== e.wr || bus.WriteData_out_WB !== e.wd) begin
      errors++; $display("FAIL alu got rw=%b wr=%0d wd=%h want rw=%b wr=%0d wd=%h", bus.RegWrite_out_WB, bus.WriteRegister_out_WB, bus.WriteData_out_WB, e.rw, e.wr, e.wd);
    end
  endtask

  task automatic test_load();
    // {size, signed, addr, readData, expected data}
    logic [1:0]  szT [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b10};
    logic        sgT [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] adT [6] = '{32'h2, 32'h2, 32'h2, 32'h3, 32'h1, 32'h0};
    logic [31:0] rdT [6] = '{32'h0080FF11, 32'h0080FF11, 32'h80010000, 32'h80010000, 32'h8765ABCD, 32'h0080FF11};
    logic [31:0] wdT [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h8765ABCD, 32'h00000011};
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 1, 1, 0, szT[i], sgT[i], 5'd12, adT[i], rdT[i], 32'h0);
      sbQ.push_back('{1'b1, 5'd12, wdT[i]});
      @(negedge Clk);
      e = sbQ.pop_front();
      checks++;
      if (bus.RegWrite_out_WB !== e.rw || bus.WriteRegister_out_WB !== e.wr || bus.WriteData_out_WB !== e.wd) begin
        errors++; $display("FAIL load%0d got rw=%b wr=%0d wd=%h want rw=%b wr=%0d wd=%h", i, bus.RegWrite_out_WB, bus.WriteRegister_out_WB, bus.WriteData_out_WB, e.rw, e.wr, e.wd);
      end
    end
  endtask

  task automatic test_jal();
    drive(1, 0, 1, 1, 1, 2'b10, 1, 5'd5, 32'h3, 32'hFFFFFFFF, 32'h00400010);
    sbQ.push_back('{1'b1, 5'd31, 32'h00400010});
    @(negedge Clk);
    e = sbQ.pop_front();
    checks++;
    if (bus.RegWrite_out_WB !== e.rw || bus.WriteRegister_out_WB !== e.wr || bus.WriteData_out_WB !== e.wd) begin
      errors++; $display("FAIL jal got rw=%b wr=%0d wd=%h want rw=%b wr=%0d wd=%h", bus.RegWrite_out_WB, bus.WriteRegister_out_WB, bus.WriteData_out_WB, e.rw, e.wr, e.wd);
    end
  endtask

  task automatic test_zero_flush();
    pulse_reset();
    drive(1, 0, 1, 0, 0, 2'b00, 0, 5'd0, 32'hABCD, 32'h0, 32'h0);
    @(negedge Clk);
    checks++; if (bus.RegWrite_out_WB !== 1'b0) begin errors++; $display("FAIL dest0_rw got %b want 0", bus.RegWrite_out_WB); end
    pulse_reset();
    drive(1, 1, 1, 0, 0, 2'b00, 0, 5'd4, 32'h42, 32'h0, 32'h0);
    @(negedge Clk);
    checks++; if (bus.RegWrite_out_WB !== 1'b0) begin errors++; $display("FAIL flush_rw got %b want 0", bus.RegWrite_out_WB); end
    drive(0, 0, 0, 0, 0, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge Clk);
    checks++; if (bus.Retired_out_WB !== 32'h0) begin errors++; $display("FAIL flush_ret got %h want 0", bus.Retired_out_WB); end
  endtask

  task automatic test_stall();
    drive(1, 0, 1, 0, 0, 2'b00, 0, 5'd9, 32'hAA, 32'h0, 32'h0);
    sbQ.push_back('{1'b1, 5'd9, 32'hAA});
    @(negedge Clk);
    e = sbQ.pop_front();
    checks++;
    if (bus.RegWrite_out_WB !== e.rw || bus.WriteRegister_out_WB !== e.wr || bus.WriteData_out_WB !== e.wd) begin
      errors++; $display("FAIL stall_load got rw=%b wr=%0d wd=%h want rw=%b wr=%0d wd=%h", bus.RegWrite_out_WB, bus.WriteRegister_out_WB, bus.WriteData_out_WB, e.rw, e.wr, e.wd);
    end
    bus.Stall_in_WB = 1'b1;
    drive(1, 0, 1, 0, 0, 2'b00, 0, 5'd3, 32'h55, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      checks++;
      if (bus.RegWrite_out_WB !== 1'b1 || bus.WriteRegister_out_WB !== 5'd9 || bus.WriteData_out_WB !== 32'hAA) begin
        errors++; $display("FAIL stall_hold%0d got rw=%b wr=%0d wd=%h want rw=1 wr=9 wd=000000aa", c, bus.RegWrite_out_WB, bus.WriteRegister_out_WB, bus.WriteData_out_WB);
      end
    end
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (bus.RegWrite_out_WB !== 1'b0 || bus.WriteRegister_out_WB !== 5'd0 || bus.WriteData_out_WB !== 32'h0 || bus.Retired_out_WB !== 32'h0) begin
      errors++; $display("FAIL stall_reset got rw=%b wr=%0d wd=%h ret=%h want all 0", bus.RegWrite_out_WB, bus.WriteRegister_out_WB, bus.WriteData_out_WB, bus.Retired_out_WB);
    end
    Reset = 1'b0;
    bus.Stall_in_WB = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic        v, f, rw, m2r, jal, sg;
    logic [1:0]  sz;
    logic [4:0]  wr;
    logic [31:0] alu, rd, pc;
    for (int i = 0; i < 20; i++) begin
      v = 1'($urandom_range(0, 3) != 0); f = 1'($urandom_range(0, 7) == 0);
      rw = 1'($urandom); m2r = 1'($urandom); jal = 1'($urandom_range(0, 5) == 0);
      sg = 1'($urandom); sz = 2'($urandom); wr = 5'($urandom);
      alu = $urandom; rd = $urandom; pc = $urandom;
      drive(v, f, rw, m2r, jal, sz, sg, wr, alu, rd, pc);
      sbQ.push_back(model(v, f, rw, m2r, jal, sz, sg, wr, alu, rd, pc));
      @(negedge Clk);
      e = sbQ.pop_front();
      checks++;
      if (bus.RegWrite_out_WB !== e.rw || bus.WriteRegister_out_WB !== e.wr || bus.WriteData_out_WB !== e.wd) begin
        errors++; $display("FAIL b2b%0d got rw=%b wr=%0d wd=%h want rw=%b wr=%0d wd=%h", i, bus.RegWrite_out_WB, bus.WriteRegister_out_WB, bus.WriteData_out_WB, e.rw, e.wr, e.wd);
      end
    end
    drive(0, 0, 0, 0, 0, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_retire();
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, 0, 0, 2'b00, 0, 5'd1, 32'(i), 32'h0, 32'h0);
      @(negedge Clk);
    end
    drive(0, 0, 0, 0, 0, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge Clk);
`ifdef WB_RETIRE_CNT_EN
    checks++; if (bus.Retired_out_WB !== 32'd10) begin errors++; $display("FAIL retire10 got %0d want 10", bus.Retired_out_WB); end
    dut.retiredCnt_reg <= 32'hFFFFFFFF;
    drive(1, 0, 1, 0, 0, 2'b00, 0, 5'd1, 32'h0, 32'h0, 32'h0);
    @(negedge Clk);
    drive(0, 0, 0, 0, 0, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge Clk);
    checks++; if (bus.Retired_out_WB !== 32'h0) begin errors++; $display("FAIL retire_wrap got %h want 0", bus.Retired_out_WB); end
`else
    checks++; if (bus.Retired_out_WB !== 32'h0) begin errors++; $display("FAIL retire_off got %h want 0", bus.Retired_out_WB); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_jal();
    test_zero_flush();
    test_stall();
    test_back_to_back();
    test_retire();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
